// File: rtl/pc_unit_ras.sv
// Program-counter unit with stall, trap/ERET and a circular return-address stack.
// Optional misaligned-redirect trapping is built when PC_MISALIGN_CHECK_EN is defined.
module pc_unit_ras #(
    parameter int                ADDR_W       = 32,
    parameter int                INST_BYTES   = 4,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'h0040_0000,
    parameter logic [ADDR_W-1:0] TRAP_VECTOR  = 32'h8000_0180,
    parameter int                RAS_DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic [2:0]        cmd,
    input  logic [ADDR_W-1:0] load_pc,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] inc_pc,
    output logic [ADDR_W-1:0] epc,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_ovf,
    output logic              ras_udf,
    output logic              misalign
);

    localparam int                PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int                CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(INST_BYTES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(RAS_DEPTH);

    typedef enum logic [2:0] {
        CMD_NONE       = 3'd0,
        CMD_INC        = 3'd1,
        CMD_INC_OFFSET = 3'd2,
        CMD_LOAD       = 3'd3,
        CMD_CALL       = 3'd4,
        CMD_RET        = 3'd5,
        CMD_TRAP       = 3'd6,
        CMD_ERET       = 3'd7
    } cmd_e;

    // Occupancy counter saturates at the stack depth; overflowing pushes recycle the oldest slot.
    function automatic logic [CNT_W-1:0] ras_cnt_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] ras_cnt_dec(input logic [CNT_W-1:0] cnt);
        return (cnt == '0) ? cnt : cnt - CNT_W'(1);
    endfunction

    logic [ADDR_W-1:0] pc_p1;
    logic [ADDR_W-1:0] epc_p1;
    logic [PTR_W-1:0]  wr_ptr_p1;
    logic [CNT_W-1:0]  cnt_p1;
    logic              ovf_p1;
    logic              udf_p1;
    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];

    cmd_e              cmd_dec;
    logic [ADDR_W-1:0] top_entry;
    logic [ADDR_W-1:0] target_p0;
    logic [ADDR_W-1:0] next_pc_p0;
    logic [ADDR_W-1:0] next_epc_p0;
    logic              redirect_p0;
    logic              push_p0;
    logic              pop_p0;
    logic              udf_p0;
`ifdef PC_MISALIGN_CHECK_EN
    logic              mis_p0;
    logic              mis_p1;
`endif

    assign cmd_dec   = cmd_e'(cmd);
    assign inc_pc    = pc_p1 + STEP;
    assign ras_empty = (cnt_p1 == '0);
    assign ras_full  = (cnt_p1 == CNT_MAX);
    // wr_ptr points at the next free slot, so the most recent push sits one below it.
    assign top_entry = ras_mem[wr_ptr_p1 - PTR_W'(1)];

    // Stage p0: next-state selection from cmd
    always_comb begin
        next_pc_p0  = pc_p1;
        next_epc_p0 = epc_p1;
        target_p0   = inc_pc;
        redirect_p0 = 1'b0;
        push_p0     = 1'b0;
        pop_p0      = 1'b0;
        udf_p0      = 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
        mis_p0      = 1'b0;
`endif
        if (!stall) begin
            case (cmd_dec)
                CMD_INC: next_pc_p0 = inc_pc;
                CMD_INC_OFFSET: begin
                    target_p0   = inc_pc + load_pc;
                    redirect_p0 = 1'b1;
                end
                CMD_LOAD: begin
                    target_p0   = load_pc;
                    redirect_p0 = 1'b1;
                end
                CMD_CALL: begin
                    target_p0   = load_pc;
                    redirect_p0 = 1'b1;
                    push_p0     = 1'b1;
                end
                CMD_RET: begin
                    redirect_p0 = 1'b1;
                    if (ras_empty) begin
                        target_p0 = inc_pc;
                        udf_p0    = 1'b1;
                    end else begin
                        target_p0 = top_entry;
                        pop_p0    = 1'b1;
                    end
                end
                CMD_TRAP: begin
                    next_epc_p0 = pc_p1;
                    next_pc_p0  = TRAP_VECTOR;
                end
                CMD_ERET: begin
                    target_p0   = epc_p1;
                    redirect_p0 = 1'b1;
                end
                default: next_pc_p0 = pc_p1;
            endcase
            if (redirect_p0) next_pc_p0 = target_p0;
`ifdef PC_MISALIGN_CHECK_EN
            // A misaligned redirect becomes a trap and leaves the RAS untouched.
            if (redirect_p0 && (target_p0[1:0] != 2'b00)) begin
                next_pc_p0  = TRAP_VECTOR;
                next_epc_p0 = pc_p1;
                push_p0     = 1'b0;
                pop_p0      = 1'b0;
                mis_p0      = 1'b1;
            end
`endif
        end
    end

    // Stage p1: architectural state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_p1     <= RESET_VECTOR;
            epc_p1    <= '0;
            wr_ptr_p1 <= '0;
            cnt_p1    <= '0;
            ovf_p1    <= 1'b0;
            udf_p1    <= 1'b0;
        end else begin
            pc_p1  <= next_pc_p0;
            epc_p1 <= next_epc_p0;
            udf_p1 <= udf_p0;
            if (push_p0) begin
                wr_ptr_p1 <= wr_ptr_p1 + PTR_W'(1);
                cnt_p1    <= ras_cnt_inc(cnt_p1);
                if (ras_full) ovf_p1 <= 1'b1;
            end else if (pop_p0) begin
                wr_ptr_p1 <= wr_ptr_p1 - PTR_W'(1);
                cnt_p1    <= ras_cnt_dec(cnt_p1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_p0) ras_mem[wr_ptr_p1] <= inc_pc;
    end

`ifdef PC_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mis_p1 <= 1'b0;
        else        mis_p1 <= mis_p0;
    end
    assign misalign = mis_p1;
`else
    assign misalign = 1'b0;
`endif

    assign pc      = pc_p1;
    assign epc     = epc_p1;
    assign ras_ovf = ovf_p1;
    assign ras_udf = udf_p1;

endmodule

// File: tb/tb_pc_unit_ras.sv
// Bench for pc_unit_ras: directed scenarios then random commands against a queue-based model.
module tb_pc_unit_ras;

    localparam logic [31:0] RV    = 32'h0040_0000;
    localparam logic [31:0] TV    = 32'h8000_0180;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic [2:0]  cmd = 3'd0;
    logic [31:0] load_pc = '0;
    logic [31:0] pc, inc_pc, epc;
    logic        ras_empty, ras_full, ras_ovf, ras_udf, misalign;

    pc_unit_ras dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .cmd(cmd), .load_pc(load_pc),
        .pc(pc), .inc_pc(inc_pc), .epc(epc), .ras_empty(ras_empty), .ras_full(ras_full),
        .ras_ovf(ras_ovf), .ras_udf(ras_udf), .misalign(misalign)
    );

    always #5 clk = ~clk;

    // Reference model: return stack as a queue, newest entry at the back.
    logic [31:0] m_pc, m_epc;
    logic [31:0] ras_q[$];
    logic        m_ovf, m_udf, m_mis;
    int          n_assert = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ":pc"},        pc,               m_pc);
        check({ctx, ":inc_pc"},    inc_pc,           m_pc + 32'd4);
        check({ctx, ":epc"},       epc,              m_epc);
        check({ctx, ":ras_empty"}, 32'(ras_empty),   32'(ras_q.size() == 0));
        check({ctx, ":ras_full"},  32'(ras_full),    32'(ras_q.size() == DEPTH));
        check({ctx, ":ras_ovf"},   32'(ras_ovf),     32'(m_ovf));
        check({ctx, ":ras_udf"},   32'(ras_udf),     32'(m_udf));
        check({ctx, ":misalign"},  32'(misalign),    32'(m_mis));
    endtask

    task automatic model_step(input logic [2:0] c, input logic [31:0] ld, input logic st);
        logic [31:0] nxt, tgt;
        logic        redir, do_push, do_pop;
        m_udf = 1'b0;
        m_mis = 1'b0;
        if (st) return;
        nxt = m_pc + 32'd4;
        tgt = nxt;
        redir = 1'b0; do_push = 1'b0; do_pop = 1'b0;
        case (c)
            3'd1: m_pc = nxt;
            3'd2: begin tgt = nxt + ld; redir = 1'b1; end
            3'd3: begin tgt = ld; redir = 1'b1; end
            3'd4: begin tgt = ld; redir = 1'b1; do_push = 1'b1; end
            3'd5: begin
                redir = 1'b1;
                if (ras_q.size() == 0) m_udf = 1'b1;
                else begin tgt = ras_q[$]; do_pop = 1'b1; end
            end
            3'd6: begin m_epc = m_pc; m_pc = TV; end
            3'd7: begin tgt = m_epc; redir = 1'b1; end
            default: ;
        endcase
`ifdef PC_MISALIGN_CHECK_EN
        if (redir && (tgt % 4) != 0) begin
            m_epc = m_pc; tgt = TV; do_push = 1'b0; do_pop = 1'b0; m_mis = 1'b1;
        end
`endif
        if (do_push) begin
            if (ras_q.size() == DEPTH) begin
                void'(ras_q.pop_front());
                m_ovf = 1'b1;
            end
            ras_q.push_back(nxt);
        end
        if (do_pop) void'(ras_q.pop_back());
        if (redir) m_pc = tgt;
    endtask

    task automatic step(input logic [2:0] c, input logic [31:0] ld, input logic st, input string ctx);
        cmd = c; load_pc = ld; stall = st;
        model_step(c, ld, st);
        @(posedge clk);
        #1;
        check_all(ctx);
    endtask

    // Asserts reset mid-cycle and checks before any clock edge arrives.
    task automatic do_reset(input string ctx);
        #2;
        rst_n = 1'b0;
        #1;
        m_pc = RV; m_epc = '0; ras_q.delete();
        m_ovf = 1'b0; m_udf = 1'b0; m_mis = 1'b0;
        check_all(ctx);
        #2;
        rst_n = 1'b1;
        cmd = 3'd0; stall = 1'b0;
    endtask

    initial begin
        logic [2:0]  rc;
        logic [31:0] rl;
        logic        rs;
        #1;
        do_reset("reset0");
        check("reset0_pc_const", pc, 32'h0040_0000);

        step(3'd1, '0, 1'b0, "inc1");
        step(3'd1, '0, 1'b0, "inc2");
        step(3'd1, '0, 1'b0, "inc3");
        check("inc3_pc_const", pc, 32'h0040_000C);
        step(3'd1, '0, 1'b0, "inc4");

        step(3'd4, 32'h0040_1000, 1'b0, "call");
        check("call_pc_const", pc, 32'h0040_1000);
        step(3'd1, '0, 1'b0, "call_inc");
        step(3'd5, '0, 1'b0, "ret");
        check("ret_pc_const", pc, 32'h0040_0014);
        check("ret_empty_const", 32'(ras_empty), 32'd1);

        for (int i = 0; i < 5; i++) step(3'd4, 32'h0050_0000 + 32'(i) * 32'h40, 1'b0, "nest_call");
        check("nest_ovf_const", 32'(ras_ovf), 32'd1);
        for (int i = 0; i < 5; i++) step(3'd5, '0, 1'b0, "nest_ret");
        check("nest_udf_const", 32'(ras_udf), 32'd1);
        step(3'd0, '0, 1'b0, "udf_clear");

        step(3'd4, 32'h0060_0000, 1'b0, "pre_stall_call");
        for (int i = 0; i < 3; i++) step(3'd3, 32'h1234_5678, 1'b1, "stall");
        step(3'd3, 32'h1234_5678, 1'b0, "stall_release");
        check("stall_release_const", pc, 32'h1234_5678);

        step(3'd3, 32'h0040_0020, 1'b0, "pre_trap");
        step(3'd6, '0, 1'b0, "trap");
        check("trap_pc_const", pc, 32'h8000_0180);
        check("trap_epc_const", epc, 32'h0040_0020);
        step(3'd7, '0, 1'b0, "eret");
        check("eret_pc_const", pc, 32'h0040_0020);

        step(3'd3, 32'h0040_0002, 1'b0, "misalign_load");
`ifdef PC_MISALIGN_CHECK_EN
        check("misalign_pc_const", pc, 32'h8000_0180);
`else
        check("misalign_pc_const", pc, 32'h0040_0002);
`endif

        step(3'd3, 32'hFFFF_FFFC, 1'b0, "wrap_load");
        step(3'd1, '0, 1'b0, "wrap_inc");
        check("wrap_pc_const", pc, 32'h0000_0000);
        step(3'd3, 32'h0040_0000, 1'b0, "neg_load");
        step(3'd2, 32'hFFFF_FFF8, 1'b0, "neg_offset");
        check("neg_offset_const", pc, 32'h003F_FFFC);

        step(3'd4, 32'h0070_0000, 1'b0, "call_before_reset");
        do_reset("reset_mid_call");
        step(3'd5, '0, 1'b0, "ret_after_reset");

        for (int i = 0; i < 400; i++) begin
            rc = 3'($urandom_range(0, 7));
            rs = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 7))
                0:       rl = $urandom;
                1, 2:    rl = $urandom & 32'hFFFF_FFFC;
                3:       rl = 32'h0 - (32'($urandom_range(1, 64)) << 2);
                default: rl = 32'h0040_0000 + (32'($urandom_range(0, 1023)) << 2);
            endcase
            step(rc, rl, rs, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
